// File: rtl/levi_pkg.sv
// Shared definitions for the levitation observer datapath: x1 width,
// ramp-loader state encoding and a signed saturation helper.
package levi_pkg;

  localparam int W_X1 = 18;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    RAMP = 2'd2
  } ramp_state_e;

  // Clamp a W_X1+1-bit signed intermediate to the W_X1-bit signed range.
  function automatic logic signed [W_X1-1:0] sat_x1(input logic signed [W_X1:0] v);
    logic signed [W_X1:0] vmax;
    logic signed [W_X1:0] vmin;
    vmax = {2'b00, {(W_X1-1){1'b1}}};
    vmin = {2'b11, {(W_X1-1){1'b0}}};
    if (v > vmax)      return vmax[W_X1-1:0];
    else if (v < vmin) return vmin[W_X1-1:0];
    else               return v[W_X1-1:0];
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Sample-tick prescaler: counts 0..TICK_DIV-1 while enabled, flags the last
// count as a one-cycle tick, and restarts from 0 whenever enable drops.
module tick_prescaler #(
  parameter int TICK_DIV = 500
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  output logic tick
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  // Free-running divider, held at zero while disabled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)         cnt <= '0;
    else if (!enable)     cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                  cnt <= cnt + 1'b1;
  end

  // Gated by enable so a falling enable on the tick cycle suppresses it.
  assign tick = enable && (cnt == LAST);

endmodule

// File: rtl/x1_init_ramp_loader.sv
// Walks the observer x1 state towards the Nios-written target in bounded
// steps, one step per sample tick, so software writes never inject a step
// discontinuity into the loop.
module x1_init_ramp_loader
  import levi_pkg::*;
#(
  parameter int W        = W_X1,
  parameter int STEP     = 64,
  parameter int TICK_DIV = 500
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] x1_init,
  input  logic         enable,
  input  logic         force_load,
  output logic [W-1:0] x1_value,
  output logic         x1_valid,
  output logic         busy,
  output logic         done
);

  localparam logic signed [W:0] STEP_S = (W+1)'(STEP);

  ramp_state_e       state;
  logic [W-1:0]      target_r;
  logic              tick;
  logic signed [W:0] x_ext;
  logic signed [W:0] diff;
  logic signed [W:0] stepped;
  logic              in_reach;
  logic              mismatch;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (enable),
    .tick    (tick)
  );

  // Single capture register on the PIO word; all comparisons use target_r.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) target_r <= '0;
    else          target_r <= x1_init;
  end

  // Widened by one bit so the extreme full-scale swing cannot wrap.
  assign x_ext    = $signed({x1_value[W-1], x1_value});
  assign diff     = $signed({target_r[W-1], target_r}) - x_ext;
  assign in_reach = (diff >= -STEP_S) && (diff <= STEP_S);
  assign stepped  = diff[W] ? (x_ext - STEP_S) : (x_ext + STEP_S);
  assign mismatch = (target_r != x1_value);

  // Ramp FSM with registered outputs; enable low dominates, then force_load.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      x1_value <= '0;
      x1_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      x1_valid <= 1'b0;
      done     <= 1'b0;
      if (!enable) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else if (force_load) begin
        x1_value <= target_r;
        state    <= HOLD;
        busy     <= 1'b0;
        done     <= 1'b1;
        x1_valid <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            state <= mismatch ? RAMP : HOLD;
            busy  <= mismatch;
          end
          HOLD: begin
            x1_valid <= tick;
            if (mismatch) begin
              state <= RAMP;
              busy  <= 1'b1;
            end
          end
          RAMP: begin
            if (tick) begin
              x1_valid <= 1'b1;
              if (in_reach) begin
                x1_value <= target_r;
                done     <= 1'b1;
                state    <= HOLD;
                busy     <= 1'b0;
              end else begin
                x1_value <= sat_x1(stepped);
              end
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/x1_init_ramp_loader.md
Name: x1_init_ramp_loader

Overview:
Downstream consumer of the 18-bit x1 initial-state PIO word written by the Nios.
- Interprets the word as signed Q-format position.
- Walks the levitation observer's x1 state from its current value to the new target in bounded steps, one step per sample tick.
- Presents x1 plus a per-tick valid strobe to the observer/controller datapath, so a software write never produces a step discontinuity in the loop.

Parameters:
- W, 18, data width; must equal the PIO out_port width.
- STEP, 64, maximum |delta| applied per tick; unsigned, 1..2^(W-1)-1.
- TICK_DIV, 500, clk cycles per sample tick; >= 2.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- x1_init  in  W  target from PIO out_port, signed two's complement
- enable  in  1  1 = run; 0 = freeze and idle
- force_load  in  1  single-cycle pulse: jump x1 to target, no ramp
- x1_value  out  W  current x1 state, signed
- x1_valid  out  1  1-cycle pulse when x1_value updated on a tick
- busy  out  1  high while in RAMP
- done  out  1  1-cycle pulse on the tick that x1_value reaches target

Behaviour:
- Clock and reset: single clock; reset asynchronous, active-low.
- Reset values: x1_value=0, target=0, x1_valid=0, busy=0, done=0, state=IDLE, tick counter=0.
- Input capture:
  - x1_init is registered once to give target_r.
  - A PIO write visible on x1_init at cycle n appears in target_r at cycle n+1.
  - Comparison against x1_value uses target_r.
- Tick counter:
  - Counts 0..TICK_DIV-1 only while enable=1, then wraps to 0.
  - tick = 1 on the cycle the counter equals TICK_DIV-1.
  - enable=0 clears the counter to 0.
- States: IDLE, HOLD, RAMP.
  - IDLE: entered on reset or enable=0, from any state, on the next cycle. x1_value is held; busy=0. On enable=1, go to RAMP if target_r != x1_value, else HOLD.
  - HOLD: x1_value == target_r. Go to RAMP on the cycle target_r != x1_value.
  - RAMP: busy=1. On each tick, compute diff = target_r - x1_value in W+1 bits.
    - If |diff| <= STEP: x1_value <= target_r, done=1, go to HOLD.
    - Otherwise: x1_value <= x1_value + STEP if diff > 0, else x1_value - STEP.
- Arithmetic: W+1-bit signed; result saturated to [-2^(W-1), 2^(W-1)-1]. Saturation cannot trigger when STEP is in range; the clamp is kept as a guard.
- x1_valid: 1 on every tick while state != IDLE, including HOLD ticks (sample stream continues). The pulse coincides with the cycle the new x1_value is visible.
- Retarget mid-ramp: a target_r change while in RAMP takes effect on the next tick. No restart; the direction may reverse.
- force_load:
  - When enable=1, at the next clock: x1_value <= target_r, state=HOLD, done=1, x1_valid=1.
  - Overrides a coincident tick.
  - Ignored when enable=0.
- Coincident enable fall and tick: enable=0 wins; no update, no valid.
- Extreme swing: target -131072 from 131071 ramps without overflow; the last step is partial.

Decomposition:
- Shared levi_pkg:
  - state enum (IDLE, HOLD, RAMP)
  - W_X1 = 18 constant
  - signed saturate function, reusable by observer stages
- One natural sub-module: tick_prescaler (counter, enable-clear, tick pulse), also reusable for ADC/DAC sample strobes.
- Remaining logic is a single FSM plus datapath.

Test Plan:
All tests use STEP=16 and TICK_DIV=4.
- Reset release, enable=1, x1_init=0 -> HOLD; x1_valid every 4 cycles; x1_value=0; busy=0.
- x1_init=40 -> ticks give x1_value 16, 32, 40; done on the third tick; busy low the next cycle; HOLD.
- x1_init=-40 (0x3FFD8) from 0 -> x1_value -16, -32, -40; done once.
- Mid-ramp at x1_value=32, x1_init changes 100 -> 0 -> next ticks 16, 0; done; no overshoot.
- force_load with x1_init=1000 in RAMP -> x1_value=1000 next cycle; done=1; x1_valid=1; HOLD.
- Second case, enable low / reset:
  - enable=0 mid-ramp at 48 -> IDLE, x1_value stays 48, no x1_valid.
  - Re-enable -> first update 4 cycles later.
  - Async reset_n low mid-cycle -> all outputs 0 immediately.
